llpage_arb: RTL and testbench
=============================

// Module: llpage_arb
//
// PURPOSE
//   Shares the single page-request interface (par/parr) of the link list manager among
//   `sources` read ports. Arbitration is round-robin, with one transaction in flight.
//   A grant is held from request acceptance until the page-return handshake completes.
//   The returned page goes only to the granted read port. Sits between the llrdport
//   instances and the llmanager page-allocate interface.
//
// PARAMETERS
//   lpsz     8   page number width
//   sources  4   number of read ports (>=2)
//   srcsz    2   grant index width; must satisfy 2**srcsz >= sources
//
// PORTS
//   clk           in   1        clock; all logic on posedge
//   reset         in   1        synchronous, active-high
//   rp_par_srdy   in   sources  per-port page request valid
//   rp_par_drdy   out  sources  per-port request accept (one-hot or zero)
//   rp_parr_srdy  out  sources  per-port page return valid (one-hot or zero)
//   rp_parr_drdy  in   sources  per-port page return ready
//   rp_parr_page  out  lpsz     returned page number, shared by all ports
//   par_srdy      out  1        page request to manager
//   par_drdy      in   1        manager accepts request
//   parr_srdy     in   1        manager page return valid
//   parr_drdy     out  1        page return ready to manager
//   parr_page     in   lpsz     page number from manager
//   gnt_src       out  srcsz    index of the granted / last granted port
//   busy          out  1        transaction in flight (state != IDLE)
//
// BEHAVIOUR
//   State machine:
//   - IDLE -> REQ when any rp_par_srdy is set.
//   - REQ -> RSP on par_srdy & par_drdy.
//   - RSP -> IDLE on parr_srdy & parr_drdy.
//   Reset values:
//   - state=IDLE, rr_ptr=0, gnt_src=0.
//   - par_srdy=0, parr_drdy=0, rp_par_drdy=0, rp_parr_srdy=0, busy=0.
//   - rp_parr_page is not reset; it is a pass-through of parr_page.
//   Arbitration, in IDLE only:
//   - Grant the first set rp_par_srdy bit, searching upward from rr_ptr with wrap at sources-1.
//   - gnt_src is registered; state becomes REQ on the next edge.
//   - Requests arriving during REQ or RSP are not sampled until IDLE.
//   REQ state:
//   - par_srdy=1, a registered state decode.
//   - rp_par_drdy[gnt_src] = par_drdy, combinational, same cycle as the manager accept.
//   - The grant is latched. A requester that drops rp_par_srdy during REQ does not cancel
//     the forwarded request; the page is still returned to that port.
//   RSP state:
//   - rp_parr_srdy[gnt_src] = parr_srdy.
//   - parr_drdy = rp_parr_drdy[gnt_src].
//   - rp_parr_page = parr_page.
//   - On transfer: rr_ptr <= (gnt_src == sources-1) ? 0 : gnt_src+1, then IDLE.
//   Non-granted ports:
//   - Their rp_par_drdy and rp_parr_srdy bits stay 0 in every state.
//   - parr_srdy arriving outside RSP is not acknowledged (parr_drdy=0).
//   Latency:
//   - Request seen in IDLE on cycle N -> par_srdy=1 on cycle N+1.
//   - Minimum 3 cycles per transaction: IDLE, REQ, RSP.
//   - Each state can stall indefinitely on the matching handshake.
//   Fairness:
//   - A port that keeps requesting is served at least once every `sources` transactions.
//   Reset mid-operation:
//   - Forces IDLE within one cycle and drops the in-flight transaction.
//   - The manager shares the same reset, so no page is leaked.
//   Width rules:
//   - rr_ptr and gnt_src are srcsz bits.
//   - Index values >= sources are never produced.
//
// TESTING
//   1. Single request: port 2 holds rp_par_srdy, manager returns page 8'h05
//      -> gnt_src=2; rp_par_drdy=4'b0100 for one cycle; rp_parr_srdy=4'b0100 with
//      rp_parr_page=5; rr_ptr=3 afterwards.
//   2. All four ports request continuously for 8 transactions -> grant order
//      0,1,2,3,0,1,2,3; no two rp_* bits ever set in the same cycle.
//   3. Manager stalls: par_drdy low for 5 cycles, then parr_srdy low for 4 cycles
//      -> par_srdy stays 1 throughout REQ; grant unchanged; busy stays 1; no
//      rp_parr_srdy pulse before parr_srdy.
//   4. Port 1 drops rp_par_srdy during REQ -> request still completes; page delivered
//      to port 1 only (rp_parr_srdy=4'b0010).
//   5. Reset asserted while in RSP -> next cycle state=IDLE, busy=0, all outputs 0,
//      rr_ptr=0; the following request from port 3 is granted normally.
//   6. Requests from ports 0 and 3 with rr_ptr=1 -> port 3 granted first, then
//      port 0 (wrap-around search).

Source files
------------

// File: rtl/llpage_arb.sv
// llpage_arb
//   Round-robin arbiter that lets several llrdport read ports share the single
//   page-allocate interface (par/parr) of the link list manager. Only one
//   transaction is in flight at a time. The grant is taken in IDLE and held
//   until the page-return handshake completes. The returned page is steered
//   only to the granted port.
//
//   Ports
//     clk, reset        clock and synchronous active-high reset
//     rp_par_srdy/drdy  per-port page request valid / accept (accept is one-hot or zero)
//     rp_parr_srdy/drdy per-port page return valid (one-hot or zero) / ready
//     rp_parr_page      returned page number, shared by all ports
//     par_srdy/drdy     page request to / accept from the manager
//     parr_srdy/drdy    page return valid from / ready to the manager
//     parr_page         page number from the manager
//     gnt_src           index of the granted (or last granted) port
//     busy              a transaction is in flight

module llpage_arb #(
    parameter int lpsz    = 8,
    parameter int sources = 4,
    parameter int srcsz   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [sources-1:0] rp_par_srdy,
    output logic [sources-1:0] rp_par_drdy,
    output logic [sources-1:0] rp_parr_srdy,
    input  logic [sources-1:0] rp_parr_drdy,
    output logic [lpsz-1:0]    rp_parr_page,
    output logic               par_srdy,
    input  logic               par_drdy,
    input  logic               parr_srdy,
    output logic               parr_drdy,
    input  logic [lpsz-1:0]    parr_page,
    output logic [srcsz-1:0]   gnt_src,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [srcsz-1:0]   rr_ptr;
    logic [srcsz-1:0]   next_gnt;
    logic               any_req;
    logic               found_hi;
    logic               found_lo;
    logic [srcsz-1:0]   pick_hi;
    logic [srcsz-1:0]   pick_lo;
    logic [sources-1:0] gnt_onehot;
    logic               req_xfer;
    logic               rsp_xfer;

    // Round-robin search: the first requester at or above rr_ptr wins; if
    // there is none, the lowest requester wins, which is the wrap-around case.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int i = 0; i < sources; i++) begin
            if (!found_hi && rp_par_srdy[i] && (i >= int'(rr_ptr))) begin
                found_hi = 1'b1;
                pick_hi  = srcsz'(i);
            end
            if (!found_lo && rp_par_srdy[i]) begin
                found_lo = 1'b1;
                pick_lo  = srcsz'(i);
            end
        end
        next_gnt = found_hi ? pick_hi : pick_lo;
        any_req  = found_lo;
    end

    assign gnt_onehot = sources'(1) << gnt_src;
    assign req_xfer   = (state == REQ) && par_drdy;
    assign rsp_xfer   = (state == RSP) && parr_srdy && parr_drdy;

    // State register, with the grant and the round-robin pointer. The grant is
    // sampled only in IDLE, so requests during REQ/RSP wait for the next round.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            gnt_src <= '0;
        end else begin
            state <= next_state;
            if ((state == IDLE) && any_req) begin
                gnt_src <= next_gnt;
            end
            if (rsp_xfer) begin
                rr_ptr <= (gnt_src == srcsz'(sources - 1)) ? '0 : gnt_src + 1'b1;
            end
        end
    end

    // Next-state logic; each state waits indefinitely on its own handshake.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req)  next_state = REQ;
            REQ:     if (req_xfer) next_state = RSP;
            RSP:     if (rsp_xfer) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode. The manager accept and page return are routed only to the
    // granted port, so the other ports never see a handshake bit.
    always_comb begin
        par_srdy     = (state == REQ);
        busy         = (state != IDLE);
        rp_par_drdy  = req_xfer ? gnt_onehot : '0;
        rp_parr_srdy = ((state == RSP) && parr_srdy) ? gnt_onehot : '0;
        parr_drdy    = (state == RSP) && (|(rp_parr_drdy & gnt_onehot));
        rp_parr_page = parr_page;
    end

endmodule

// File: tb/tb_llpage_arb.sv
// tb_llpage_arb
//   Directed bench for llpage_arb with four read ports. Each step drives the
//   inputs just after a rising edge, lets them settle, compares the outputs
//   against hand-computed values and then advances one clock.

module tb_llpage_arb;

    logic       clk;
    logic       reset;
    logic [3:0] rp_par_srdy;
    logic [3:0] rp_par_drdy;
    logic [3:0] rp_parr_srdy;
    logic [3:0] rp_parr_drdy;
    logic [7:0] rp_parr_page;
    logic       par_srdy;
    logic       par_drdy;
    logic       parr_srdy;
    logic       parr_drdy;
    logic [7:0] parr_page;
    logic [1:0] gnt_src;
    logic       busy;

    int checks = 0;
    int errors = 0;

    llpage_arb #(.lpsz(8), .sources(4), .srcsz(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .rp_par_srdy  (rp_par_srdy),
        .rp_par_drdy  (rp_par_drdy),
        .rp_parr_srdy (rp_parr_srdy),
        .rp_parr_drdy (rp_parr_drdy),
        .rp_parr_page (rp_parr_page),
        .par_srdy     (par_srdy),
        .par_drdy     (par_drdy),
        .parr_srdy    (parr_srdy),
        .parr_drdy    (parr_drdy),
        .parr_page    (parr_page),
        .gnt_src      (gnt_src),
        .busy         (busy)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one set of inputs and let the combinational outputs settle.
    task automatic applyStimulus(input logic [3:0] req, input logic pdrdy,
                                 input logic psrdy, input logic [3:0] rdrdy,
                                 input logic [7:0] page);
        rp_par_srdy  = req;
        par_drdy     = pdrdy;
        parr_srdy    = psrdy;
        rp_parr_drdy = rdrdy;
        parr_page    = page;
        #1;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One full transaction: request in IDLE, accept in REQ, page return in RSP.
    // With drop set the requester releases rp_par_srdy once it has been granted.
    task automatic runTxn(input logic [3:0] req, input logic drop,
                          input logic [1:0] exp_gnt, input logic [7:0] page);
        logic [3:0] exp_hot;
        exp_hot = 4'b0001 << exp_gnt;
        applyStimulus(req, 1'b0, 1'b0, 4'hF, page);
        tick();
        checkOutput("req_par_srdy", 32'(par_srdy), 32'd1);
        checkOutput("req_gnt_src", 32'(gnt_src), 32'(exp_gnt));
        applyStimulus(drop ? 4'b0000 : req, 1'b1, 1'b0, 4'hF, page);
        checkOutput("req_rp_par_drdy", 32'(rp_par_drdy), 32'(exp_hot));
        tick();
        applyStimulus(drop ? 4'b0000 : req, 1'b0, 1'b1, 4'hF, page);
        checkOutput("rsp_rp_parr_srdy", 32'(rp_parr_srdy), 32'(exp_hot));
        checkOutput("rsp_page", 32'(rp_parr_page), 32'(page));
        checkOutput("rsp_parr_drdy", 32'(parr_drdy), 32'd1);
        checkOutput("rsp_rp_par_drdy", 32'(rp_par_drdy), 32'd0);
        tick();
        applyStimulus(drop ? 4'b0000 : req, 1'b0, 1'b0, 4'hF, page);
        checkOutput("idle_busy", 32'(busy), 32'd0);
    endtask

    // Directed sequence covering reset, single requests, round-robin order,
    // stalls, requester drop, reset mid-transaction and wrap-around.
    initial begin
        reset = 1'b1;
        applyStimulus(4'b0000, 1'b0, 1'b0, 4'h0, 8'h00);
        tick();
        tick();
        reset = 1'b0;

        // Reset state, with a stray page return offered outside RSP.
        applyStimulus(4'b0000, 1'b1, 1'b1, 4'hF, 8'h00);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_par_srdy", 32'(par_srdy), 32'd0);
        checkOutput("rst_gnt_src", 32'(gnt_src), 32'd0);
        checkOutput("rst_parr_drdy", 32'(parr_drdy), 32'd0);
        checkOutput("rst_rp_par_drdy", 32'(rp_par_drdy), 32'd0);
        checkOutput("rst_rp_parr_srdy", 32'(rp_parr_srdy), 32'd0);
        tick();
        checkOutput("rst_stay_idle", 32'(busy), 32'd0);

        // Single request from port 2; afterwards rr_ptr=3, so 0 and 3 -> 3.
        runTxn(4'b0100, 1'b0, 2'd2, 8'h05);
        runTxn(4'b1001, 1'b0, 2'd3, 8'h11);

        // All ports requesting: strict rotation over eight transactions.
        for (int i = 0; i < 8; i++) begin
            runTxn(4'b1111, 1'b0, 2'(i % 4), 8'(8'h20 + i));
        end

        // Manager stalls in REQ for 5 cycles, then in RSP for 4 cycles.
        applyStimulus(4'b0010, 1'b0, 1'b0, 4'hF, 8'h33);
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_par_srdy", 32'(par_srdy), 32'd1);
            checkOutput("stall_gnt_src", 32'(gnt_src), 32'd1);
            checkOutput("stall_req_drdy", 32'(rp_par_drdy), 32'd0);
            tick();
        end
        applyStimulus(4'b0010, 1'b1, 1'b0, 4'hF, 8'h33);
        checkOutput("stall_accept", 32'(rp_par_drdy), 32'b0010);
        tick();
        applyStimulus(4'b0010, 1'b0, 1'b0, 4'hF, 8'h33);
        for (int i = 0; i < 4; i++) begin
            checkOutput("stall_rsp_busy", 32'(busy), 32'd1);
            checkOutput("stall_no_return", 32'(rp_parr_srdy), 32'd0);
            checkOutput("stall_rsp_par_srdy", 32'(par_srdy), 32'd0);
            tick();
        end
        // Only non-granted ports ready: the manager must not be acknowledged.
        applyStimulus(4'b0010, 1'b0, 1'b1, 4'b1101, 8'h33);
        checkOutput("wrong_port_ready", 32'(parr_drdy), 32'd0);
        checkOutput("return_valid_held", 32'(rp_parr_srdy), 32'b0010);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b1, 4'b0010, 8'h33);
        checkOutput("still_in_rsp", 32'(busy), 32'd1);
        checkOutput("stall_release", 32'(parr_drdy), 32'd1);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0, 4'hF, 8'h00);
        checkOutput("stall_done", 32'(busy), 32'd0);

        // rr_ptr=2 now; port 1 alone wins after wrap and then drops its request.
        runTxn(4'b0010, 1'b1, 2'd1, 8'h44);

        // Reset while in RSP; rr_ptr=2 so port 0 is granted first.
        applyStimulus(4'b0001, 1'b0, 1'b0, 4'hF, 8'h55);
        tick();
        checkOutput("pre_rst_gnt", 32'(gnt_src), 32'd0);
        applyStimulus(4'b0001, 1'b1, 1'b0, 4'hF, 8'h55);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0, 4'hF, 8'h55);
        checkOutput("pre_rst_rsp", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(4'b0000, 1'b0, 1'b1, 4'hF, 8'h55);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_gnt", 32'(gnt_src), 32'd0);
        checkOutput("mid_rst_parr_drdy", 32'(parr_drdy), 32'd0);
        checkOutput("mid_rst_rp_parr_srdy", 32'(rp_parr_srdy), 32'd0);
        runTxn(4'b1000, 1'b0, 2'd3, 8'h66);

        // rr_ptr back to 0: grant port 0 to set rr_ptr=1, then 0 and 3 contend.
        runTxn(4'b0001, 1'b0, 2'd0, 8'h77);
        runTxn(4'b1001, 1'b0, 2'd3, 8'h88);
        runTxn(4'b1001, 1'b0, 2'd0, 8'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
